// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage core.
// Single-cycle ALU ops land in the EX/MEM slot one edge after acceptance.
// Optional macro EX_MUL_EN: when defined, op 8 (MUL) runs on an iterative
// shift-add multiplier (IDLE/BUSY/DONE FSM); when undefined, op 8 is illegal.
module ex_stage #(
  parameter int MUL_ITER = 32,
  parameter int OP_W     = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [31:0]     next_pc_in,
  input  logic [OP_W-1:0] opcode_in,
  input  logic [31:0]     rgS1_data_in,
  input  logic [31:0]     rgS2_data_in,
  input  logic [31:0]     immed_in,
  input  logic            y_sel_in,
  input  logic [3:0]      control_in,
  input  logic [4:0]      rgD_index_in,
  input  logic            stall_mem_in,
  input  logic            flush_in,
  output logic            stall_out,
  output logic            valid_out,
  output logic [31:0]     alu_result_out,
  output logic [31:0]     store_data_out,
  output logic [31:0]     next_pc_out,
  output logic [3:0]      control_out,
  output logic [4:0]      rgD_index_out
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_PASSY = 4'd9;

  logic [3:0]  alu_op;
  logic [31:0] y_val;
  logic [31:0] alu_val;
  logic        alu_legal;
  logic        unused_opcode_bits;

  // Values the EX/MEM slot would load on this edge
  logic        ex_load;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_store;
  logic [31:0] ex_pc;
  logic [3:0]  ex_ctrl;
  logic [4:0]  ex_rd;

  // EX/MEM register state
  logic        valid_reg;
  logic [31:0] result_reg;
  logic [31:0] store_reg;
  logic [31:0] pc_reg;
  logic [3:0]  ctrl_reg;
  logic [4:0]  rd_reg;

  assign alu_op             = opcode_in[3:0];
  assign y_val              = y_sel_in ? immed_in : rgS2_data_in;
  assign unused_opcode_bits = ^opcode_in[OP_W-1:4];

`ifdef EX_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam int         CNT_W  = $clog2(MUL_ITER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg, state_next;
  logic        mul_start;
  logic        mul_step;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0] mcand_reg;
  logic [31:0] mplier_reg;
  logic [31:0] acc_reg;
  // Passthrough fields of the MUL, captured at start so DONE does not
  // depend on ID/EX still presenting the same instruction
  logic [31:0] m_store_reg;
  logic [31:0] m_pc_reg;
  logic [3:0]  m_ctrl_reg;
  logic [4:0]  m_rd_reg;
`else
  localparam int unused_mul_iter = MUL_ITER;
`endif

  // Single-cycle ALU; anything not decoded here is illegal and yields 0
  always_comb begin
    alu_val   = 32'd0;
    alu_legal = 1'b1;
    case (alu_op)
      OP_ADD:   alu_val = rgS1_data_in + y_val;
      OP_SUB:   alu_val = rgS1_data_in - y_val;
      OP_AND:   alu_val = rgS1_data_in & y_val;
      OP_OR:    alu_val = rgS1_data_in | y_val;
      OP_XOR:   alu_val = rgS1_data_in ^ y_val;
      OP_SLL:   alu_val = rgS1_data_in << y_val[4:0];
      OP_SRL:   alu_val = rgS1_data_in >> y_val[4:0];
      OP_SLT:   alu_val = {31'd0, ($signed(rgS1_data_in) < $signed(y_val))};
      OP_PASSY: alu_val = y_val;
      default:  alu_legal = 1'b0;
    endcase
  end

  // Next-state / stall / EX/MEM load selection
  always_comb begin
    ex_load   = ~stall_mem_in;
    ex_valid  = valid_in;
    ex_result = alu_val;
    ex_store  = rgS2_data_in;
    ex_pc     = next_pc_in;
    ex_ctrl   = alu_legal ? control_in : 4'd0;
    ex_rd     = rgD_index_in;
    stall_out = stall_mem_in;
`ifdef EX_MUL_EN
    state_next = state_reg;
    mul_start  = 1'b0;
    mul_step   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_in && (alu_op == OP_MUL)) begin
          stall_out  = 1'b1;
          mul_start  = 1'b1;
          ex_valid   = 1'b0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        mul_step  = 1'b1;
        ex_valid  = 1'b0;
        if (cnt_reg == CNT_W'(MUL_ITER - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The MUL still held in ID/EX is consumed on the emitting edge
        ex_valid  = 1'b1;
        ex_result = acc_reg;
        ex_store  = m_store_reg;
        ex_pc     = m_pc_reg;
        ex_ctrl   = m_ctrl_reg;
        ex_rd     = m_rd_reg;
        if (!stall_mem_in) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush_in) begin
      state_next = IDLE;
    end
`endif
  end

`ifdef EX_MUL_EN
  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Shift-add multiplier datapath: one multiplier bit per BUSY cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      mcand_reg   <= 32'd0;
      mplier_reg  <= 32'd0;
      acc_reg     <= 32'd0;
      m_store_reg <= 32'd0;
      m_pc_reg    <= 32'd0;
      m_ctrl_reg  <= 4'd0;
      m_rd_reg    <= 5'd0;
    end else if (flush_in) begin
      cnt_reg <= '0;
    end else if (mul_start) begin
      cnt_reg     <= '0;
      mcand_reg   <= rgS1_data_in;
      mplier_reg  <= y_val;
      acc_reg     <= 32'd0;
      m_store_reg <= rgS2_data_in;
      m_pc_reg    <= next_pc_in;
      m_ctrl_reg  <= control_in;
      m_rd_reg    <= rgD_index_in;
    end else if (mul_step) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end
`endif

  // EX/MEM slot: flush kills it, memory stall holds it, otherwise it loads.
  // Data fields (result included) only change when a valid instruction lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg  <= 1'b0;
      result_reg <= 32'd0;
      store_reg  <= 32'd0;
      pc_reg     <= 32'd0;
      ctrl_reg   <= 4'd0;
      rd_reg     <= 5'd0;
    end else if (flush_in) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= 4'd0;
    end else if (ex_load) begin
      valid_reg <= ex_valid;
      ctrl_reg  <= ex_valid ? ex_ctrl : 4'd0;
      if (ex_valid) begin
        result_reg <= ex_result;
        store_reg  <= ex_store;
        pc_reg     <= ex_pc;
        rd_reg     <= ex_rd;
      end
    end
  end

  assign valid_out      = valid_reg;
  assign alu_result_out = result_reg;
  assign store_data_out = store_reg;
  assign next_pc_out    = pc_reg;
  assign control_out    = ctrl_reg;
  assign rgD_index_out  = rd_reg;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven vectors, hand-written multi-cycle sequences and a
// randomized run checked against a behavioural model of the execute stage.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] next_pc_in = 32'd0;
  logic [13:0] opcode_in = 14'd0;
  logic [31:0] rgS1_data_in = 32'd0;
  logic [31:0] rgS2_data_in = 32'd0;
  logic [31:0] immed_in = 32'd0;
  logic        y_sel_in = 1'b0;
  logic [3:0]  control_in = 4'd0;
  logic [4:0]  rgD_index_in = 5'd0;
  logic        stall_mem_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] alu_result_out;
  logic [31:0] store_data_out;
  logic [31:0] next_pc_out;
  logic [3:0]  control_out;
  logic [4:0]  rgD_index_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .next_pc_in(next_pc_in),
    .opcode_in(opcode_in), .rgS1_data_in(rgS1_data_in), .rgS2_data_in(rgS2_data_in),
    .immed_in(immed_in), .y_sel_in(y_sel_in), .control_in(control_in),
    .rgD_index_in(rgD_index_in), .stall_mem_in(stall_mem_in), .flush_in(flush_in),
    .stall_out(stall_out), .valid_out(valid_out), .alu_result_out(alu_result_out),
    .store_data_out(store_data_out), .next_pc_out(next_pc_out),
    .control_out(control_out), .rgD_index_out(rgD_index_out)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        ysel;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic [3:0]  exp_ctrl;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                               input logic ysel, input logic [3:0] ctrl, input logic [4:0] rd,
                               input logic [31:0] exp_res, input logic [3:0] exp_ctrl);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.ysel = ysel; v.ctrl = ctrl; v.rd = rd;
    v.exp_res = exp_res; v.exp_ctrl = exp_ctrl;
    return v;
  endfunction

  // Reference ALU from the op table: returns {legal, result}
  function automatic logic [32:0] ref_alu(input int op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] prod;
    int          sh;
    sh   = int'(y % 32);
    prod = {32'd0, x} * {32'd0, y};
    case (op)
      0: return {1'b1, x + y};
      1: return {1'b1, x - y};
      2: return {1'b1, x & y};
      3: return {1'b1, x | y};
      4: return {1'b1, x ^ y};
      5: return {1'b1, x << sh};
      6: return {1'b1, x >> sh};
      7: return {1'b1, ((int'(x) < int'(y)) ? 32'd1 : 32'd0)};
`ifdef EX_MUL_EN
      8: return {1'b1, prod[31:0]};
`endif
      9: return {1'b1, y};
      default: return {1'b0, 32'd0};
    endcase
  endfunction

  function automatic logic [31:0] store_of(input logic [31:0] x, input logic [31:0] y, input logic ysel);
    return ysel ? (x ^ 32'h5A5A_5A5A) : y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic ysel, input logic [3:0] c, input logic [4:0] rd, input logic [31:0] pc);
    valid_in     = v;
    opcode_in    = {10'h2A5, op};
    rgS1_data_in = x;
    y_sel_in     = ysel;
    immed_in     = ysel ? y : ~y;
    rgS2_data_in = store_of(x, y, ysel);
    control_in   = c;
    rgD_index_in = rd;
    next_pc_in   = pc;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 5'd0, 32'd0);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    logic [31:0] pc;
    pc = 32'h0000_1000 + 32'(idx * 4);
    drive(1'b1, v.op, v.x, v.y, v.ysel, v.ctrl, v.rd, pc);
    #1;
    chk($sformatf("v%0d_stall", idx), 32'(stall_out), 32'd0);
    tick();
    chk($sformatf("v%0d_valid", idx), 32'(valid_out), 32'd1);
    chk($sformatf("v%0d_result", idx), alu_result_out, v.exp_res);
    chk($sformatf("v%0d_ctrl", idx), 32'(control_out), 32'(v.exp_ctrl));
    chk($sformatf("v%0d_rd", idx), 32'(rgD_index_out), 32'(v.rd));
    chk($sformatf("v%0d_store", idx), store_data_out, store_of(v.x, v.y, v.ysel));
    chk($sformatf("v%0d_pc", idx), next_pc_out, pc);
    $display("vec %0d op=%0d x=%h y=%h -> result=%h ctrl=%b", idx, v.op, v.x, v.y,
             alu_result_out, control_out);
  endtask

`ifdef EX_MUL_EN
  // MUL presented with stall_mem low; optionally stall in DONE for done_stall cycles
  task automatic run_mul(input logic [31:0] x, input logic [31:0] y, input int done_stall);
    logic [63:0] prod;
    int          sc;
    bit          bubbles_ok;
    bit          stall_ok;
    prod = {32'd0, x} * {32'd0, y};
    drive(1'b1, 4'd8, x, y, 1'b1, 4'b1001, 5'd9, 32'h0000_4000);
    sc = 0;
    bubbles_ok = 1'b1;
    stall_ok = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      #1;
      if (stall_out === 1'b1) sc++;
      tick();
      if (valid_out !== 1'b0 || control_out !== 4'd0) bubbles_ok = 1'b0;
    end
    chk("mul_stall_cycles", 32'(sc), 32'd33);
    chk("mul_bubbles", 32'(bubbles_ok), 32'd1);
    if (done_stall > 0) begin
      stall_mem_in = 1'b1;
      for (int s = 0; s < done_stall; s++) begin
        #1;
        if (stall_out !== 1'b1) stall_ok = 1'b0;
        tick();
        if (valid_out !== 1'b0 || control_out !== 4'd0) stall_ok = 1'b0;
      end
      chk("mul_done_stall_hold", 32'(stall_ok), 32'd1);
      stall_mem_in = 1'b0;
    end
    #1;
    chk("mul_done_stall_out", 32'(stall_out), 32'd0);
    tick();
    idle_inputs();
    chk("mul_valid", 32'(valid_out), 32'd1);
    chk("mul_result", alu_result_out, prod[31:0]);
    chk("mul_ctrl", 32'(control_out), 32'b1001);
    chk("mul_rd", 32'(rgD_index_out), 32'd9);
    chk("mul_pc", next_pc_out, 32'h0000_4000);
    $display("mul x=%h y=%h done_stall=%0d -> result=%h", x, y, done_stall, alu_result_out);
  endtask
`endif

  // Global time limit so the run always ends
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    logic        mv, ms_v;
    logic [31:0] mr, mst, mp;
    logic [3:0]  mc;
    logic [4:0]  md;
    logic [32:0] r;

    vecs[0]  = mkv(4'd0, 32'hFFFF_FFFF, 32'd1,        1'b1, 4'b1000, 5'd5,  32'h0000_0000, 4'b1000);
    vecs[1]  = mkv(4'd7, 32'h8000_0000, 32'd1,        1'b1, 4'b0010, 5'd6,  32'h0000_0001, 4'b0010);
    vecs[2]  = mkv(4'd6, 32'h8000_0000, 32'd4,        1'b1, 4'b1000, 5'd7,  32'h0800_0000, 4'b1000);
    vecs[3]  = mkv(4'd1, 32'd5,         32'd7,        1'b0, 4'b1000, 5'd8,  32'hFFFF_FFFE, 4'b1000);
    vecs[4]  = mkv(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 4'b1000, 5'd10, 32'h00F0_00F0, 4'b1000);
    vecs[5]  = mkv(4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 4'b1000, 5'd11, 32'hFFF0_FFF0, 4'b1000);
    vecs[6]  = mkv(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 4'b1000, 5'd12, 32'hFF00_FF00, 4'b1000);
    vecs[7]  = mkv(4'd5, 32'd1,         32'h0000_003F, 1'b1, 4'b1000, 5'd13, 32'h8000_0000, 4'b1000);
    vecs[8]  = mkv(4'd9, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 4'b0110, 5'd14, 32'hDEAD_BEEF, 4'b0110);
    vecs[9]  = mkv(4'd12, 32'h1111_1111, 32'h2222_2222, 1'b0, 4'b1111, 5'd15, 32'h0000_0000, 4'b0000);
    vecs[10] = mkv(4'd7, 32'd1,         32'h8000_0000, 1'b0, 4'b0001, 5'd16, 32'h0000_0000, 4'b0001);
    vecs[11] = mkv(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b1010, 5'd31, 32'h0000_0000, 4'b0000);

    // Reset state
    idle_inputs();
    tick();
    tick();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_result", alu_result_out, 32'd0);
    chk("rst_ctrl", 32'(control_out), 32'd0);
    chk("rst_pc", next_pc_out, 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      apply_vec(vecs[i], i);
    end

    // No valid input and no stall: a bubble is loaded
    idle_inputs();
    tick();
    chk("bubble_valid", 32'(valid_out), 32'd0);
    chk("bubble_ctrl", 32'(control_out), 32'd0);
    $display("bubble valid=%0b ctrl=%b", valid_out, control_out);

`ifdef EX_MUL_EN
    run_mul(32'd7, 32'hFFFF_FFFF, 0);
    run_mul(32'h0001_2345, 32'h0001_0001, 3);

    // Flush in BUSY while memory is stalled
    apply_vec(mkv(4'd0, 32'd10, 32'd20, 1'b1, 4'b1100, 5'd3, 32'd30, 4'b1100), 20);
    stall_mem_in = 1'b1;
    drive(1'b1, 4'd8, 32'd3, 32'd5, 1'b1, 4'b1001, 5'd9, 32'h0000_5000);
    tick();
    chk("flush_pre_hold_valid", 32'(valid_out), 32'd1);
    chk("flush_pre_hold_ctrl", 32'(control_out), 32'b1100);
    repeat (10) tick();
    chk("flush_busy_stall", 32'(stall_out), 32'd1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    stall_mem_in = 1'b0;
    idle_inputs();
    #1;
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_ctrl", 32'(control_out), 32'd0);
    chk("flush_stall", 32'(stall_out), 32'd0);
    $display("flush valid=%0b ctrl=%b stall=%0b", valid_out, control_out, stall_out);
    apply_vec(mkv(4'd0, 32'd1, 32'd2, 1'b1, 4'b1000, 5'd4, 32'd3, 4'b1000), 21);
`endif

    // Reset asserted mid-operation
    apply_vec(mkv(4'd0, 32'h0000_0100, 32'h0000_0023, 1'b0, 4'b1010, 5'd17, 32'h0000_0123, 4'b1010), 22);
`ifdef EX_MUL_EN
    drive(1'b1, 4'd8, 32'd3, 32'd5, 1'b1, 4'b1001, 5'd9, 32'h0000_6000);
    repeat (15) tick();
`endif
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_result", alu_result_out, 32'd0);
    chk("midrst_store", store_data_out, 32'd0);
    chk("midrst_pc", next_pc_out, 32'd0);
    chk("midrst_ctrl", 32'(control_out), 32'd0);
    chk("midrst_rd", 32'(rgD_index_out), 32'd0);
    chk("midrst_stall", 32'(stall_out), 32'd0);
    $display("mid reset outputs result=%h valid=%0b", alu_result_out, valid_out);
    tick();
    reset = 1'b1;
    tick();
`ifdef EX_MUL_EN
    run_mul(32'd3, 32'd5, 0);
`else
    // Without the multiplier MUL is illegal: result 0, control 0, latency 1
    apply_vec(mkv(4'd8, 32'd3, 32'd5, 1'b1, 4'b1001, 5'd9, 32'd0, 4'b0000), 23);
`endif

    // Randomized run against the model, from a fresh reset
    idle_inputs();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    mv = 1'b0; mr = 32'd0; mst = 32'd0; mp = 32'd0; mc = 4'd0; md = 5'd0;
    for (int i = 0; i < 400; i++) begin
      int          op;
      logic [31:0] x, y;
      logic        ys;
      logic [3:0]  c;
      logic [4:0]  rd;
      logic [31:0] pc;
      ms_v = ($urandom_range(0, 3) != 0);
`ifdef EX_MUL_EN
      do op = int'($urandom_range(0, 15)); while (op == 8);
`else
      op = int'($urandom_range(0, 15));
`endif
      x  = $urandom;
      y  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      ys = 1'($urandom_range(0, 1));
      c  = 4'($urandom_range(0, 15));
      rd = 5'($urandom_range(0, 31));
      pc = $urandom;
      drive(ms_v, 4'(op), x, y, ys, c, rd, pc);
      stall_mem_in = ($urandom_range(0, 3) == 0);
      flush_in     = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd_stall", 32'(stall_out), 32'(stall_mem_in));
      r = ref_alu(op, x, y);
      if (flush_in) begin
        mv = 1'b0;
        mc = 4'd0;
      end else if (!stall_mem_in) begin
        if (ms_v) begin
          mv  = 1'b1;
          mr  = r[31:0];
          mc  = r[32] ? c : 4'd0;
          mst = store_of(x, y, ys);
          mp  = pc;
          md  = rd;
        end else begin
          mv = 1'b0;
          mc = 4'd0;
        end
      end
      tick();
      chk("rnd_valid", 32'(valid_out), 32'(mv));
      chk("rnd_result", alu_result_out, mr);
      chk("rnd_ctrl", 32'(control_out), 32'(mc));
      chk("rnd_store", store_data_out, mst);
      chk("rnd_pc", next_pc_out, mp);
      chk("rnd_rd", 32'(rgD_index_out), 32'(md));
    end
    stall_mem_in = 1'b0;
    flush_in = 1'b0;
    idle_inputs();
    $display("random run of 400 cycles complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
